// File: rtl/window_gen_55_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_55_pkg
// Purpose  : Shared constants and the window packing helper for the 5x5
//            sliding-window generator and the downstream convolution stage.
// Contents : KERNEL, WIN_ELEMS, NUM_LB, win_idx()
// Revision : 1.0 - initial release
// ============================================================================
package window_gen_55_pkg;

  localparam int KERNEL    = 5;
  localparam int WIN_ELEMS = KERNEL * KERNEL;
  // One line buffer per window row above the live input row.
  localparam int NUM_LB    = KERNEL - 1;

  // Position of window element (row, col) inside the packed window word.
  // Row 0 is the top of the window and col 0 is its left edge.
  function automatic int win_idx(input int row, input int col);
    return KERNEL * row + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_gen_55_if.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_55_if
// Purpose  : Pixel-in / window-out bundle of the 5x5 window generator.
// Ports    : ivalid, idata      - pixel strobe and raster-order pixel
//            ovalid, odata      - window strobe and packed 25-pixel window
//            frame_done         - pulse with the last window of a frame
// Modports : master (pixel source / window sink), slave (window generator)
// Revision : 1.0 - initial release
// ============================================================================
interface window_gen_55_if #(
  parameter int DATA_WIDTH = 8
);

  logic                                                  ivalid;
  logic [DATA_WIDTH-1:0]                                 idata;
  logic                                                  ovalid;
  logic [window_gen_55_pkg::WIN_ELEMS*DATA_WIDTH-1:0]    odata;
  logic                                                  frame_done;

  modport master (
    output ivalid, idata,
    input  ovalid, odata, frame_done
  );

  modport slave (
    input  ivalid, idata,
    output ovalid, odata, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/window_gen_55_line_buf_row.sv
`default_nettype none
// ============================================================================
// Module   : line_buf_row
// Purpose  : One image row of pixel storage. Single port, read-before-write:
//            rdata_o shows the old contents of addr_i during the cycle in
//            which the same address is overwritten.
// Ports    : clk      - clock
//            we_i     - write enable
//            addr_i   - column address
//            wdata_i  - pixel to store
//            rdata_o  - pixel currently stored at addr_i
// Revision : 1.0 - initial release
// ============================================================================
module line_buf_row #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 28,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  wire logic                  clk,
  input  wire logic                  we_i,
  input  wire logic [ADDR_W-1:0]     addr_i,
  input  wire logic [DATA_WIDTH-1:0] wdata_i,
  output logic      [DATA_WIDTH-1:0] rdata_o
);

  // Contents are deliberately not reset; stale data is always overwritten
  // before it can reach an emitted window.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_gen_55.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_55
// Purpose  : Streaming 5x5 sliding-window generator. Takes one raster-order
//            pixel per valid cycle and emits a packed 25-pixel window for
//            every position whose full neighbourhood lies inside the image.
// Ports    : clk   - clock, rising edge
//            rstn  - asynchronous active-low reset
//            bus   - window_gen_55_if.slave (ivalid/idata in,
//                    ovalid/odata/frame_done out)
// Revision : 1.0 - initial release
// ============================================================================
module window_gen_55
  import window_gen_55_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input wire logic         clk,
  input wire logic         rstn,
  window_gen_55_if.slave   bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL - 1);

  // --------------------------------------------------------------------------
  // Position counters of the incoming pixel
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.ivalid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line buffers: LB0 holds the previous row, LB3 the row four above.
  // Each buffer is fed from the read port of the one before it, so one
  // write per pixel ages every stored column by one row.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] lb_rd [NUM_LB];
  logic [DATA_WIDTH-1:0] lb_wr [NUM_LB];

  always_comb begin
    lb_wr[0] = bus.idata;
    for (int i = 1; i < NUM_LB; i++) begin
      lb_wr[i] = lb_rd[i-1];
    end
  end

  for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
    line_buf_row #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_lb (
      .clk     (clk),
      .we_i    (bus.ivalid),
      .addr_i  (col_q),
      .wdata_i (lb_wr[i]),
      .rdata_o (lb_rd[i])
    );
  end

  // --------------------------------------------------------------------------
  // Window register array, shifted left by one column per accepted pixel.
  // The new right column is, top to bottom, LB3..LB0 then the live pixel.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] win_q   [KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0] win_d   [KERNEL][KERNEL];
  logic [DATA_WIDTH-1:0] new_col [KERNEL];

  always_comb begin
    new_col[KERNEL-1] = bus.idata;
    for (int i = 0; i < NUM_LB; i++) begin
      new_col[NUM_LB-1-i] = lb_rd[i];
    end
  end

  always_comb begin
    win_d = win_q;
    if (bus.ivalid) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL-1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KERNEL-1] = new_col[r];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output strobes. Positions in rows/cols 0..3 are suppressed, which also
  // hides stale columns from the previous row and unwritten line buffers.
  // --------------------------------------------------------------------------
  logic ovalid_q, ovalid_d;
  logic frame_done_q, frame_done_d;

  always_comb begin
    ovalid_d     = bus.ivalid && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    frame_done_d = bus.ivalid && (row_q == ROW_LAST)  && (col_q == COL_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      ovalid_q     <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ovalid_q     <= ovalid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign bus.ovalid     = ovalid_q;
  assign bus.frame_done = frame_done_q;

  for (genvar r = 0; r < KERNEL; r++) begin : g_out_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_out_col
      localparam int K = win_idx(r, c);
      assign bus.odata[K*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_gen_55.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_gen_55
// Purpose  : Directed self-checking bench for window_gen_55 on a 28x28 image
//            with pixel(r,c) = (28r+c) mod 256 (optionally inverted).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_gen_55;

  localparam int DW   = 8;
  localparam int IW   = 28;
  localparam int IH   = 28;
  localparam int WB   = 25 * DW;
  localparam int NPIX = IW * IH;
  localparam int NWIN = (IW - 4) * (IH - 4);

  logic clk;
  logic rstn;

  window_gen_55_if #(.DATA_WIDTH(DW)) bus ();

  window_gen_55 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [WB-1:0] got,
                           input logic [WB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [DW-1:0] pixv(input bit inv, input int r, input int c);
    logic [DW-1:0] v;
    v = DW'((IW * r + c) % 256);
    return inv ? 8'd255 - v : v;
  endfunction

  // Window number idx of a frame corresponds to pixel (4+idx/24, 4+idx%24).
  function automatic logic [WB-1:0] exp_win(input bit inv, input int idx);
    logic [WB-1:0] w;
    int r, c;
    r = 4 + idx / (IW - 4);
    c = 4 + idx % (IW - 4);
    w = '0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int cc = 0; cc < 5; cc++) begin
        w[(5*rr+cc)*DW +: DW] = pixv(inv, r - 4 + rr, c - 4 + cc);
      end
    end
    return w;
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [WB-1:0] got_q [$];
  logic [WB-1:0] ref_q [$];
  bit            fd_q  [$];
  int            acc_cnt   = 0;
  int            first_lat = -1;
  int            viol      = 0;
  int            fd_alone  = 0;
  bit            acc_last  = 1'b0;

  always @(posedge clk) begin
    acc_last = bus.ivalid && rstn;
    if (bus.ivalid && rstn) acc_cnt++;
  end

  always @(negedge clk) begin
    if (bus.ovalid) begin
      got_q.push_back(bus.odata);
      fd_q.push_back(bus.frame_done);
      if (first_lat < 0) first_lat = acc_cnt;
      if (!acc_last) viol++;
    end else if (bus.frame_done) begin
      fd_alone++;
    end
  end

  task automatic mon_clear();
    got_q.delete();
    fd_q.delete();
    acc_cnt   = 0;
    first_lat = -1;
    viol      = 0;
    fd_alone  = 0;
  endtask

  // --------------------------------------------------------------------------
  // Drivers
  // --------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    bus.ivalid = v;
    bus.idata  = d;
  endtask

  task automatic send_frame(input bit inv, input int gap_pct);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        while ($urandom_range(0, 99) < gap_pct) drive(1'b0, 8'hxx);
        drive(1'b1, pixv(inv, r, c));
      end
    end
  endtask

  task automatic flush();
    repeat (4) drive(1'b0, '0);
  endtask

  task automatic check_windows(input string tag, input int nfr, input bit inv2);
    int fd_cnt;
    check_val({tag, "_count"}, got_q.size(), nfr * NWIN);
    check_val({tag, "_fd_alone"}, fd_alone, 0);
    check_val({tag, "_no_acc"}, viol, 0);
    fd_cnt = 0;
    foreach (fd_q[i]) fd_cnt += int'(fd_q[i]);
    check_val({tag, "_fd_count"}, fd_cnt, nfr);
    if (fd_q.size() > 0) check_val({tag, "_fd_last"}, fd_q[fd_q.size()-1], 1);
    foreach (got_q[i]) begin
      if (i < nfr * NWIN)
        check_val($sformatf("%s_win%0d", tag, i), got_q[i],
                  exp_win((i >= NWIN) && inv2, i % NWIN));
    end
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    rstn       = 1'b0;
    bus.ivalid = 1'b0;
    bus.idata  = '0;

    // Reset state
    @(negedge clk);
    check_val("rst_ovalid", bus.ovalid, 0);
    check_val("rst_frame_done", bus.frame_done, 0);
    check_val("rst_odata", bus.odata, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    mon_clear();

    // Continuous frame
    send_frame(1'b0, 0);
    flush();
    check_val("cont_first_lat", first_lat, 117);
    check_windows("cont", 1, 1'b0);
    if (got_q.size() > 24) begin
      check_val("cont_w0_e0",   got_q[0][0*DW +: DW], 0);
      check_val("cont_w0_e12",  got_q[0][12*DW +: DW], 58);
      check_val("cont_w0_e24",  got_q[0][24*DW +: DW], 116);
      check_val("row_bnd_e0",   got_q[24][0*DW +: DW], 28);
      check_val("row_bnd_e24",  got_q[24][24*DW +: DW], 144);
    end else begin
      check_val("cont_too_few", got_q.size(), NWIN);
    end
    ref_q = got_q;

    // Same frame with random idle cycles; counters wrapped to (0,0)
    mon_clear();
    send_frame(1'b0, 40);
    flush();
    check_val("gap_count", got_q.size(), ref_q.size());
    check_val("gap_no_acc", viol, 0);
    foreach (got_q[i]) begin
      if (i < ref_q.size()) check_val($sformatf("gap_win%0d", i), got_q[i], ref_q[i]);
    end

    // Reset in the middle of a frame
    mon_clear();
    for (int i = 0; i < 300; i++) drive(1'b1, pixv(1'b0, i / IW, i % IW));
    @(posedge clk);
    #1 rstn = 1'b0;
    bus.idata = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("mid_rst_ovalid%0d", i), bus.ovalid, 0);
      check_val($sformatf("mid_rst_fd%0d", i), bus.frame_done, 0);
      check_val($sformatf("mid_rst_odata%0d", i), bus.odata, 0);
    end
    @(posedge clk);
    #1;
    bus.ivalid = 1'b0;
    rstn       = 1'b1;
    mon_clear();
    send_frame(1'b0, 0);
    flush();
    check_val("rst_first_lat", first_lat, 117);
    check_windows("rst", 1, 1'b0);

    // Back-to-back frames, the second one inverted
    mon_clear();
    send_frame(1'b0, 0);
    send_frame(1'b1, 0);
    flush();
    check_windows("b2b", 2, 1'b1);
    if (got_q.size() > NWIN) begin
      check_val("b2b_f2_e0",  got_q[NWIN][0*DW +: DW], 255);
      check_val("b2b_f2_e24", got_q[NWIN][24*DW +: DW], 139);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
